motor_drive_pwm: RTL

Parametrised N-channel H-bridge motor drive for the robot's drive train. It generates one shared-period PWM per channel with a per-channel duty command, ramps duty toward target, and enforces a ramp-down plus dead-time sequence on every forward/reverse reversal. It also provides an immediate collision kill. It sits between the drive/steering decision logic (mode and duty commands) and the H-bridge pins (enable, IN pair per channel).

---
 rtl/motor_drive_pwm.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/motor_drive_pwm.sv
// motor_drive_pwm: N-channel H-bridge drive. Each channel has a shared-period
// PWM, a duty ramp toward the commanded target, a ramp-down plus dead-time
// sequence on direction reversal, and an immediate collision kill.
module motor_drive_pwm #(
  parameter int N_CH         = 2,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PWM_HZ       = 80,
  parameter int MAX_DUTY     = 80,
  parameter int RAMP_STEP    = 10,
  parameter int DEAD_PERIODS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7*N_CH-1:0] duty_cmd,
  input  logic [2*N_CH-1:0] mode_cmd,
  input  logic              collision,
  output logic [N_CH-1:0]   hb_en,
  output logic [N_CH-1:0]   hb_in1,
  output logic [N_CH-1:0]   hb_in2,
  output logic              period_tick,
  output logic [N_CH-1:0]   at_target
);

  localparam int PERIOD_CNT = CLK_HZ / PWM_HZ;
  localparam int UNIT       = PERIOD_CNT / 100;
  localparam int CW         = $clog2(PERIOD_CNT + 1);
  localparam int DW         = $clog2(DEAD_PERIODS + 2);

  localparam logic [1:0]    M_COAST = 2'b00;
  localparam logic [1:0]    M_FWD   = 2'b01;
  localparam logic [1:0]    M_REV   = 2'b10;
  localparam logic [1:0]    M_BRAKE = 2'b11;
  localparam logic [6:0]    MAX_D   = 7'(MAX_DUTY);
  localparam logic [6:0]    STEP    = 7'(RAMP_STEP);
  localparam logic [CW-1:0] LAST    = CW'(PERIOD_CNT - 1);
  localparam logic [CW-1:0] UNIT_C  = CW'(UNIT);
  localparam logic [DW-1:0] DEAD_C  = DW'(DEAD_PERIODS);

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_RAMP_DOWN = 2'd1,
    S_DEAD      = 2'd2
  } state_t;

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic          w_bnd;
  logic          w_start;

  assign w_bnd       = (r_cnt == LAST);
  assign w_start     = (r_cnt == '0);
  assign period_tick = r_tick;

  // Shared period counter; the tick is registered so it lines up with the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_bnd ? '0 : r_cnt + CW'(1);
      r_tick <= w_bnd;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [6:0]    w_dcmd;
      logic [6:0]    w_tgt;
      logic [6:0]    w_duty_eff;
      logic [6:0]    w_ramp;
      logic [6:0]    w_dn;
      logic [6:0]    w_duty_next;
      logic [7:0]    w_sum;
      logic [1:0]    w_mcmd;
      logic [1:0]    w_am_next;
      logic          w_cmd_drive;
      logic          w_am_drive;
      state_t        w_state_next;
      logic [DW-1:0] w_dcnt_next;
      logic [CW-1:0] w_on;

      logic [6:0]    r_duty;
      logic [1:0]    r_am;
      state_t        r_state;
      logic [DW-1:0] r_dcnt;
      logic [CW-1:0] r_on;
      logic          r_en;
      logic          r_in1;
      logic          r_in2;
      logic          r_at;

      assign w_dcmd      = duty_cmd[7*gi +: 7];
      assign w_mcmd      = mode_cmd[2*gi +: 2];
      // Anything above the clamp (including 101..127) collapses to MAX_DUTY.
      assign w_tgt       = (w_dcmd > MAX_D) ? MAX_D : w_dcmd;
      assign w_cmd_drive = (w_mcmd == M_FWD) || (w_mcmd == M_REV);
      assign w_am_drive  = (r_am == M_FWD) || (r_am == M_REV);
      // A collision makes every decision see a stopped motor.
      assign w_duty_eff  = collision ? 7'd0 : r_duty;
      assign w_sum       = {1'b0, w_duty_eff} + {1'b0, STEP};
      assign w_dn        = ((STEP == 7'd0) || (w_duty_eff <= STEP)) ? 7'd0 : w_duty_eff - STEP;
      // On-count is only reloaded at the top of the period so duty never changes mid-period.
      assign w_on        = w_start ? CW'(r_duty) * UNIT_C : r_on;

      // One ramp step toward the clamped target, saturating at the target.
      always_comb begin
        w_ramp = w_tgt;
        if (STEP != 7'd0) begin
          if (w_duty_eff < w_tgt) begin
            w_ramp = (w_sum >= {1'b0, w_tgt}) ? w_tgt : w_sum[6:0];
          end else if (w_duty_eff > w_tgt) begin
            w_ramp = ((w_duty_eff - w_tgt) <= STEP) ? w_tgt : w_duty_eff - STEP;
          end
        end
      end

      // Boundary-sampled mode/duty sequencing: RUN, RAMP_DOWN before reversal, then DEAD.
      always_comb begin
        w_state_next = r_state;
        w_am_next    = r_am;
        w_duty_next  = r_duty;
        w_dcnt_next  = r_dcnt;
        if (w_bnd) begin
          case (r_state)
            S_RUN: begin
              if (w_cmd_drive && w_am_drive && (w_mcmd != r_am)) begin
                if (w_duty_eff != 7'd0) begin
                  w_state_next = S_RAMP_DOWN;
                  w_duty_next  = w_dn;
                end else begin
                  w_state_next = S_DEAD;
                  w_dcnt_next  = DEAD_C;
                end
              end else if (!w_cmd_drive) begin
                w_am_next   = w_mcmd;
                w_duty_next = 7'd0;
              end else begin
                // Coast/brake -> drive also lands here; duty is 0 so the ramp starts from 0.
                w_am_next   = w_mcmd;
                w_duty_next = w_ramp;
              end
            end
            S_RAMP_DOWN: begin
              if (w_duty_eff == 7'd0) begin
                w_state_next = S_DEAD;
                w_dcnt_next  = DEAD_C;
              end else begin
                w_duty_next = w_dn;
              end
            end
            S_DEAD: begin
              if (!collision) begin
                if (r_dcnt <= DW'(1)) begin
                  w_state_next = S_RUN;
                  w_am_next    = w_mcmd;
                  w_dcnt_next  = '0;
                end else begin
                  w_dcnt_next = r_dcnt - DW'(1);
                end
              end
            end
            default: begin
              w_state_next = S_RUN;
            end
          endcase
        end
        if (collision) begin
          w_duty_next = 7'd0;
        end
      end

      // Channel state registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= S_RUN;
          r_am    <= M_COAST;
          r_duty  <= 7'd0;
          r_dcnt  <= '0;
          r_on    <= '0;
        end else begin
          r_state <= w_state_next;
          r_am    <= w_am_next;
          r_duty  <= w_duty_next;
          r_dcnt  <= w_dcnt_next;
          r_on    <= collision ? '0 : w_on;
        end
      end

      // Registered bridge pins and at-target flag.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_en  <= 1'b0;
          r_in1 <= 1'b0;
          r_in2 <= 1'b0;
          r_at  <= 1'b0;
        end else begin
          r_at  <= (r_state == S_RUN) && (r_duty == w_tgt);
          r_en  <= 1'b0;
          r_in1 <= 1'b0;
          r_in2 <= 1'b0;
          if (r_state != S_DEAD) begin
            case (r_am)
              M_FWD: begin
                r_en  <= !collision && (r_cnt < w_on);
                r_in2 <= 1'b1;
              end
              M_REV: begin
                r_en  <= !collision && (r_cnt < w_on);
                r_in1 <= 1'b1;
              end
              M_BRAKE: begin
                r_en <= !collision;
              end
              default: begin
                r_en <= 1'b0;
              end
            endcase
          end
        end
      end

      assign hb_en[gi]     = r_en;
      assign hb_in1[gi]    = r_in1;
      assign hb_in2[gi]    = r_in2;
      assign at_target[gi] = r_at;
    end
  endgenerate

endmodule
